// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle for alu_op_sequencer.
// master = requesting decode logic, slave = the sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic                 op_valid;
    logic                 op_ready;
    logic [1:0]           op_code;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res_data;
    logic                 res_carry;
    logic                 res_overflow;
    logic                 res_err;
    logic                 busy;

    modport master (
        output op_valid, op_code, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data, res_carry, res_overflow, res_err, busy
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data, res_carry, res_overflow, res_err, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Single-issue add/sub/shift-add-multiply sequencer sharing one WIDTH-bit adder.
// Optional macro ALU_OP_SEQ_MUL_EARLY_EXIT_EN: multiply stops once the remaining multiplier is zero.
module alu_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus
);
    localparam int            CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_RSV} op_e;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0]     add_x, add_y;
    logic                 add_cin;
    logic [WIDTH:0]       sum_full;
    logic                 cin_msb;
    logic [2*WIDTH-1:0]   mul_acc;
    logic                 mul_last;

    // Shared adder: operand select depends only on the captured opcode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        add_x   = a_q;
        add_y   = b_q;
        add_cin = 1'b0;
        case (op_q)
            OP_SUB: begin
                add_y   = ~b_q;
                add_cin = 1'b1;
            end
            OP_MUL: begin
                add_x = acc_q[2*WIDTH-1:WIDTH];
                add_y = b_q[0] ? a_q : '0;
            end
            default: ;
        endcase
        sum_full = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        // Sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out directly.
        cin_msb  = add_x[WIDTH-1] ^ add_y[WIDTH-1] ^ sum_full[WIDTH-1];
        mul_acc  = {sum_full[WIDTH], sum_full[WIDTH-1:0], acc_q[WIDTH-1:1]};
`ifdef ALU_OP_SEQ_MUL_EARLY_EXIT_EN
        mul_last = (cnt_q == LAST) || (b_q[WIDTH-1:1] == '0);
`else
        mul_last = (cnt_q == LAST);
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    state_d = EXEC;
                    op_d    = op_e'(bus.op_code);
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        acc_d   = {{WIDTH{1'b0}}, sum_full[WIDTH-1:0]};
                        carry_d = sum_full[WIDTH];
                        ovf_d   = cin_msb ^ sum_full[WIDTH];
                        state_d = DONE;
                    end
                    OP_MUL: begin
                        acc_d = mul_acc;
                        b_d   = b_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (mul_last) begin
`ifdef ALU_OP_SEQ_MUL_EARLY_EXIT_EN
                            // Skipped iterations would only shift; apply them all at once.
                            acc_d = mul_acc >> (LAST - cnt_q);
`endif
                            state_d = DONE;
                        end
                    end
                    default: begin
                        acc_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so all flops update together.
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.op_ready     = (state_q == IDLE) && !rst;
    assign bus.res_valid    = (state_q == DONE);
    assign bus.res_data     = acc_q;
    assign bus.res_carry    = carry_q;
    assign bus.res_overflow = ovf_q;
    assign bus.res_err      = err_q;
    assign bus.busy         = (state_q != IDLE);
endmodule
